// File: rtl/hoplite_inject_ctrl.sv
// hoplite_inject_ctrl
// Buffers matrix elements produced by a compute core, tags each with a Hoplite
// destination {x, y} and an end-of-matrix "last" bit, and injects them into the
// router through a first-word-fall-through FIFO. A small IDLE/SEND/DONE FSM
// emits a one-cycle done pulse once the end-marked packet has left.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   in_matrix / in_matrix_en     payload and its write strobe
//   in_position / in_position_en destination {x, y} load
//   in_end_row                   advance destination Y (mod 2^COORD_WIDTH)
//   in_end                       end of matrix (marks push, or pushes terminator)
//   fifo_full                    FIFO holds FIFO_DEPTH entries
//   pkt_valid/pkt_data/pkt_ready injection handshake, pkt_data = {last,x,y,data}
//   busy, done, overflow         status (overflow is sticky until reset)
//   pkt_count                    popped-packet counter, only with HOPLITE_PKT_COUNT_EN
//
// Optional feature macro: HOPLITE_PKT_COUNT_EN
module hoplite_inject_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [DATA_WIDTH-1:0]                 in_matrix,
  input  logic                                  in_matrix_en,
  input  logic [2*COORD_WIDTH-1:0]              in_position,
  input  logic                                  in_position_en,
  input  logic                                  in_end_row,
  input  logic                                  in_end,
  output logic                                  fifo_full,
  output logic                                  pkt_valid,
  output logic [DATA_WIDTH+2*COORD_WIDTH:0]     pkt_data,
  input  logic                                  pkt_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
`ifdef HOPLITE_PKT_COUNT_EN
  ,
  output logic [15:0]                           pkt_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int POS_W = 2 * COORD_WIDTH;
  localparam int PKT_W = DATA_WIDTH + POS_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [POS_W-1:0]   dest_q, dest_d;
  logic [PKT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PKT_W-1:0]   mem_d [FIFO_DEPTH];
  logic               pkt_valid_q, pkt_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               fifo_full_q, fifo_full_d;

  logic               push_req_s, push_s, pop_s, pop_last_s;
  logic [POS_W-1:0]   dest_eff_s;
  logic [PKT_W-1:0]   entry_s, head_s;

  // FIFO datapath, destination tracking and overflow detection
  always_comb begin
    push_req_s = in_matrix_en | in_end;
    head_s     = mem_q[rd_ptr_q];
    pop_s      = pkt_valid_q & pkt_ready;
    pop_last_s = pop_s & head_s[PKT_W-1];

    // A position load in the same cycle as a push tags that push.
    if (in_position_en) dest_eff_s = in_position;
    else                dest_eff_s = dest_q;

    // in_end alone pushes a zero-payload terminator.
    if (in_matrix_en) entry_s = {in_end, dest_eff_s, in_matrix};
    else              entry_s = {1'b1, dest_eff_s, {DATA_WIDTH{1'b0}}};

    // Fullness is judged before any same-cycle pop: no push-through.
    if (push_req_s && (count_q != DEPTH_C)) push_s = 1'b1;
    else                                    push_s = 1'b0;

    if (push_req_s && (count_q == DEPTH_C)) overflow_d = 1'b1;
    else                                    overflow_d = overflow_q;

    // Row advance applies after the push has taken the current destination.
    if (in_end_row) dest_d = {dest_eff_s[POS_W-1:COORD_WIDTH],
                              dest_eff_s[COORD_WIDTH-1:0] + COORD_WIDTH'(1)};
    else            dest_d = dest_eff_s;

    mem_d = mem_q;
    if (push_s) mem_d[wr_ptr_q] = entry_s;
    else        mem_d = mem_q;

    if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else       rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state; a popped last entry wins from IDLE or SEND
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SEND: begin
        if (pop_last_s)             state_d = ST_DONE;
        else if (count_d != ZERO_C) state_d = ST_SEND;
        else                        state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered status outputs
  always_comb begin
    pkt_valid_d = (count_d != ZERO_C) && (state_d != ST_DONE);
    busy_d      = (count_d != ZERO_C) || (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    fifo_full_d = (count_d == DEPTH_C);
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage, pointers, destination and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q     <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      dest_q      <= {POS_W{1'b0}};
      pkt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      fifo_full_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {PKT_W{1'b0}};
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dest_q      <= dest_d;
      pkt_valid_q <= pkt_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      fifo_full_q <= fifo_full_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef HOPLITE_PKT_COUNT_EN
  logic [15:0] pkt_count_q, pkt_count_d;

  // Popped-packet counter, wraps naturally at 16 bits
  always_comb begin
    if (pop_s) pkt_count_d = pkt_count_q + 16'd1;
    else       pkt_count_d = pkt_count_q;
  end

  // Packet counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_q <= 16'd0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

  assign pkt_data  = head_s;
  assign pkt_valid = pkt_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign fifo_full = fifo_full_q;

endmodule
